// File: rtl/i2c_pkg.sv
// Shared FSM encoding, command values and byte-slot indices for the 16-bit register I2C master.
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE, WAIT_LOW
  } state_t;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  // Byte-index slots: write frame walks 0..(2+WR_BYTES), read jumps to B_ADDR_R after the repeated START.
  localparam logic [2:0] B_ADDR_W = 3'd0;
  localparam logic [2:0] B_REG_H  = 3'd1;
  localparam logic [2:0] B_REG_L  = 3'd2;
  localparam logic [2:0] B_DAT_H  = 3'd3;
  localparam logic [2:0] B_DAT_L  = 3'd4;
  localparam logic [2:0] B_ADDR_R = 3'd5;
endpackage

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period tick generator; the count freezes while a slave stretches SCL.
module i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && !hold && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (!en)   cnt <= '0;
    else if (!hold) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/i2c_reg16_master.sv
// I2C master for devices with 16-bit register addresses: register writes and single-byte reads.
module i2c_reg16_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV  = 125,
  parameter int WR_BYTES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_rqt,
  input  logic       cmd,
  input  logic [6:0] addr_dev,
  input  logic [7:0] addr_reg_H,
  input  logic [7:0] addr_reg_L,
  input  logic [7:0] data_wr_H,
  input  logic [7:0] data_wr_L,
  output logic       i2c_done,
  output logic       data_rdy,
  output logic [7:0] data_rd,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);
  localparam logic [2:0] LAST_WR = 3'(2 + WR_BYTES);

  state_t     state;
  logic [1:0] qcnt;
  logic [2:0] bit_cnt, byte_idx;
  logic [7:0] rx_sh, tx_byte;
  logic       cmd_r;
  logic [6:0] addr_r;
  logic [7:0] reg_h_r, reg_l_r, dat_h_r, dat_l_r;
  logic       tick, q_en;

  assign q_en = (state != IDLE) && (state != DONE) && (state != WAIT_LOW);

  // A released SCL that still reads low is a slave stretching the clock.
  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk(clk), .rst(rst), .en(q_en), .hold(!scl_oe && !scl_i), .tick(tick)
  );

  always_comb begin
    tx_byte = {addr_r, 1'b0};
    case (byte_idx)
      B_REG_H:  tx_byte = reg_h_r;
      B_REG_L:  tx_byte = reg_l_r;
      B_DAT_H:  tx_byte = dat_h_r;
      B_DAT_L:  tx_byte = dat_l_r;
      B_ADDR_R: tx_byte = {addr_r, 1'b1};
      default:  ;
    endcase
  end

  // Each bit: q0 SCL low + SDA update, q1 SCL release, q2 sample, q3 SCL low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;  qcnt <= '0;  bit_cnt <= '0;  byte_idx <= '0;  rx_sh <= '0;
      scl_oe <= 1'b0; sda_oe <= 1'b0; i2c_done <= 1'b0; data_rdy <= 1'b0;
      data_rd <= '0;  ack_err <= 1'b0;
      cmd_r <= WRITE; addr_r <= '0; reg_h_r <= '0; reg_l_r <= '0; dat_h_r <= '0; dat_l_r <= '0;
    end else begin
      i2c_done <= 1'b0;
      data_rdy <= 1'b0;
      if (tick) qcnt <= qcnt + 2'd1;
      case (state)
        IDLE: begin
          scl_oe <= 1'b0; sda_oe <= 1'b0; qcnt <= '0; bit_cnt <= '0; byte_idx <= B_ADDR_W;
          if (i2c_rqt) begin
            cmd_r <= cmd; addr_r <= addr_dev; reg_h_r <= addr_reg_H; reg_l_r <= addr_reg_L;
            dat_h_r <= data_wr_H; dat_l_r <= data_wr_L;
            ack_err <= 1'b0;
            state <= START;
          end
        end
        START: if (tick) case (qcnt)
          2'd0: begin scl_oe <= 1'b0; sda_oe <= 1'b0; end
          2'd1: sda_oe <= 1'b1;
          2'd3: begin scl_oe <= 1'b1; bit_cnt <= '0; state <= TX_BYTE; end
          default: ;
        endcase
        TX_BYTE: if (tick) case (qcnt)
          2'd0: begin scl_oe <= 1'b1; sda_oe <= ~tx_byte[3'd7 - bit_cnt]; end
          2'd1: scl_oe <= 1'b0;
          2'd3: begin
            scl_oe  <= 1'b1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_ACK;
          end
          default: ;
        endcase
        RX_ACK: if (tick) case (qcnt)
          2'd0: sda_oe <= 1'b0;
          2'd1: scl_oe <= 1'b0;
          2'd2: if (sda_i) ack_err <= 1'b1;
          2'd3: begin
            scl_oe  <= 1'b1;
            bit_cnt <= '0;
            if (ack_err)                                      state <= STOP;
            else if (cmd_r == READ && byte_idx == B_REG_L) begin
              byte_idx <= B_ADDR_R; state <= RSTART;
            end
            else if (byte_idx == B_ADDR_R)                    state <= RX_BYTE;
            else if (cmd_r == WRITE && byte_idx == LAST_WR)   state <= STOP;
            else begin byte_idx <= byte_idx + 3'd1; state <= TX_BYTE; end
          end
          default: ;
        endcase
        RSTART: if (tick) case (qcnt)
          2'd0: sda_oe <= 1'b0;
          2'd1: scl_oe <= 1'b0;
          2'd3: state <= START;
          default: ;
        endcase
        RX_BYTE: if (tick) case (qcnt)
          2'd0: sda_oe <= 1'b0;
          2'd1: scl_oe <= 1'b0;
          2'd2: rx_sh <= {rx_sh[6:0], sda_i};
          2'd3: begin
            scl_oe  <= 1'b1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= TX_NACK;
          end
          default: ;
        endcase
        TX_NACK: if (tick) case (qcnt)
          2'd0: sda_oe <= 1'b0;
          2'd1: scl_oe <= 1'b0;
          2'd3: begin scl_oe <= 1'b1; state <= STOP; end
          default: ;
        endcase
        STOP: if (tick) case (qcnt)
          2'd0: begin scl_oe <= 1'b1; sda_oe <= 1'b1; end
          2'd1: scl_oe <= 1'b0;
          2'd3: begin
            sda_oe   <= 1'b0;
            i2c_done <= 1'b1;
            state    <= DONE;
            if (cmd_r == READ && !ack_err) begin
              data_rdy <= 1'b1;
              data_rd  <= rx_sh;
            end
          end
          default: ;
        endcase
        DONE:     state <= WAIT_LOW;
        WAIT_LOW: if (!i2c_rqt) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_reg16_master.sv
// Directed bench for i2c_reg16_master with a behavioural open-drain slave on the bus.
module tb_i2c_reg16_master;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic       i2c_rqt = 1'b0, cmd = 1'b1;
  logic [6:0] addr_dev = '0;
  logic [7:0] addr_reg_H = '0, addr_reg_L = '0, data_wr_H = '0, data_wr_L = '0;
  logic       i2c_done, data_rdy, ack_err, scl_oe, sda_oe;
  logic [7:0] data_rd;
  logic       s_scl_low = 1'b0, s_sda_low = 1'b0;
  logic       scl, sda;

  assign scl = ~(scl_oe | s_scl_low);
  assign sda = ~(sda_oe | s_sda_low);

  i2c_reg16_master #(.CLK_DIV(CLK_DIV), .WR_BYTES(1)) dut (
    .clk(clk), .rst(rst), .i2c_rqt(i2c_rqt), .cmd(cmd), .addr_dev(addr_dev),
    .addr_reg_H(addr_reg_H), .addr_reg_L(addr_reg_L), .data_wr_H(data_wr_H), .data_wr_L(data_wr_L),
    .i2c_done(i2c_done), .data_rdy(data_rdy), .data_rd(data_rd), .ack_err(ack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl), .sda_i(sda)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Bus log: -1 START/Sr, -2 STOP, -3 master NACK, -4 master ACK, else master-written byte.
  int   log_q[$];
  int   nbytes = 0, nack_idx = -1, bitn = 0, scl_rises = 0, stretch_cnt = 0;
  int   done_cnt = 0, rdy_cnt = 0, rdy_solo = 0;
  logic [7:0] sh = '0, rd_data = 8'h56;
  bit   p_scl = 1, p_sda = 1, s_tx = 0, rd_pend = 0, ack_now = 1, exp_addr = 0, stretch_en = 0;

  always @(negedge clk) begin
    if (i2c_done) done_cnt++;
    if (data_rdy) rdy_cnt++;
    if (data_rdy && !i2c_done) rdy_solo++;
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) s_scl_low = 1'b0;
    end
    if (p_scl && scl && p_sda && !sda) begin
      log_q.push_back(-1); bitn = 0; s_tx = 0; rd_pend = 0; exp_addr = 1;
    end else if (p_scl && scl && !p_sda && sda) begin
      log_q.push_back(-2);
    end else if (!p_scl && scl) begin
      scl_rises++;
      if (bitn < 8) begin
        sh = {sh[6:0], sda}; bitn++;
        if (bitn == 8 && !s_tx) begin
          log_q.push_back(int'(sh));
          ack_now = (nbytes != nack_idx);
          if (exp_addr && sh[0] && ack_now) rd_pend = 1;
          exp_addr = 0;
          nbytes++;
        end
      end else begin
        if (s_tx) begin log_q.push_back(sda ? -3 : -4); s_tx = 0; end
        else if (rd_pend) begin s_tx = 1; rd_pend = 0; end
        bitn = 0;
      end
    end else if (p_scl && !scl) begin
      if (bitn == 8 && !s_tx)    s_sda_low = ack_now;
      else if (s_tx && bitn < 8) s_sda_low = !rd_data[7 - bitn];
      else                       s_sda_low = 1'b0;
      if (stretch_en && nbytes == 0 && bitn == 0 && !s_tx) begin
        s_scl_low = 1'b1; stretch_cnt = 500; stretch_en = 0;
      end
    end
    p_scl = scl; p_sda = sda;
  end

  task automatic do_xfer(input logic c, input logic [7:0] rh, input logic [7:0] rl,
                         input logic [7:0] dh, input bit drop,
                         output bit got, output int lat, output int cyc,
                         output bit rdy, output logic [7:0] rd, output bit err);
    cmd = c; addr_dev = 7'h36; addr_reg_H = rh; addr_reg_L = rl; data_wr_H = dh; data_wr_L = 8'hA5;
    i2c_rqt = 1'b1; got = 0; lat = -1; cyc = 0; rdy = 0; rd = '0; err = 0;
    while (!got && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        cmd = ~c; addr_dev = 7'h7F; addr_reg_H = ~rh; addr_reg_L = ~rl; data_wr_H = ~dh;
      end
      if (lat < 0 && sda_oe) lat = cyc;
      if (i2c_done) begin got = 1; rdy = data_rdy; rd = data_rd; err = ack_err; end
    end
    if (drop) i2c_rqt = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({scl_oe, sda_oe, i2c_done, data_rdy, ack_err} !== 5'b0) begin
      errors++; $display("FAIL reset_outs got=%b exp=00000", {scl_oe, sda_oe, i2c_done, data_rdy, ack_err}); end
    checks++; if (data_rd !== 8'h00) begin
      errors++; $display("FAIL reset_data_rd got=%h exp=00", data_rd); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({scl_oe, sda_oe, i2c_done} !== 3'b0) begin
      errors++; $display("FAIL idle_bus got=%b exp=000", {scl_oe, sda_oe, i2c_done}); end
  endtask

  task automatic test_write();
    int exp[6] = '{-1, 'h6C, 'h30, 'h00, 'h0F, -2};
    bit got, rdy, err; int lat, cyc, n0; logic [7:0] rd;
    log_q.delete(); nbytes = 0; nack_idx = -1; n0 = done_cnt;
    do_xfer(1'b1, 8'h30, 8'h00, 8'h0F, 1, got, lat, cyc, rdy, rd, err);
    checks++; if (!got) begin errors++; $display("FAIL write_done got=0 exp=1"); end
    checks++; if (lat != 2*CLK_DIV+1) begin errors++; $display("FAIL write_start_latency got=%0d exp=%0d", lat, 2*CLK_DIV+1); end
    checks++; if (err !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL write_flags got err=%b rdy=%b exp 0 0", err, rdy); end
    checks++; if (done_cnt - n0 != 1) begin errors++; $display("FAIL write_done_pulses got=%0d exp=1", done_cnt - n0); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL write_log_len got=%0d exp=6", log_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (log_q[i] != exp[i]) begin errors++; $display("FAIL write_log[%0d] got=%0d exp=%0d", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_read();
    int exp[8] = '{-1, 'h6C, 'h30, 'h0A, -1, 'h6D, -3, -2};
    bit got, rdy, err; int lat, cyc; logic [7:0] rd;
    log_q.delete(); nbytes = 0; nack_idx = -1; rd_data = 8'h56;
    do_xfer(1'b0, 8'h30, 8'h0A, 8'h00, 1, got, lat, cyc, rdy, rd, err);
    checks++; if (!got || !rdy) begin errors++; $display("FAIL read_done_rdy got done=%b rdy=%b exp 1 1", got, rdy); end
    checks++; if (rd !== 8'h56) begin errors++; $display("FAIL read_data got=%h exp=56", rd); end
    checks++; if (err !== 1'b0 || rdy_solo != 0) begin errors++; $display("FAIL read_err_solo got err=%b solo=%0d exp 0 0", err, rdy_solo); end
    checks++; if (data_rd !== 8'h56) begin errors++; $display("FAIL read_data_held got=%h exp=56", data_rd); end
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL read_log_len got=%0d exp=8", log_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (log_q[i] != exp[i]) begin errors++; $display("FAIL read_log[%0d] got=%0d exp=%0d", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_nack();
    int exp[4] = '{-1, 'h6C, 'h30, -2};
    bit got, rdy, err; int lat, cyc, r0; logic [7:0] rd;
    log_q.delete(); nbytes = 0; nack_idx = 1; r0 = rdy_cnt;
    do_xfer(1'b0, 8'h30, 8'h0A, 8'h00, 1, got, lat, cyc, rdy, rd, err);
    nack_idx = -1;
    checks++; if (!got || err !== 1'b1) begin errors++; $display("FAIL nack_done_err got done=%b err=%b exp 1 1", got, err); end
    checks++; if (rdy !== 1'b0 || rdy_cnt != r0) begin errors++; $display("FAIL nack_no_rdy got rdy=%b pulses=%0d exp 0 0", rdy, rdy_cnt - r0); end
    checks++; if (rd !== 8'h56) begin errors++; $display("FAIL nack_data_kept got=%h exp=56", rd); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_sticky got=%b exp=1", ack_err); end
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL nack_log_len got=%0d exp=4", log_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (log_q[i] != exp[i]) begin errors++; $display("FAIL nack_log[%0d] got=%0d exp=%0d", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_hold_rqt();
    bit got, rdy, err; int lat, cyc, sz, busy; logic [7:0] rd;
    log_q.delete(); nbytes = 0; busy = 0;
    do_xfer(1'b1, 8'h30, 8'h00, 8'h0F, 0, got, lat, cyc, rdy, rd, err);
    sz = log_q.size();
    repeat (5) begin @(negedge clk); if (scl_oe || sda_oe) busy++; end
    i2c_rqt = 1'b0;
    repeat (2) begin @(negedge clk); if (scl_oe || sda_oe) busy++; end
    checks++; if (!got) begin errors++; $display("FAIL hold_done got=0 exp=1"); end
    checks++; if (log_q.size() != sz || busy != 0) begin
      errors++; $display("FAIL hold_no_restart got new_events=%0d busy=%0d exp 0 0", log_q.size() - sz, busy); end
  endtask

  task automatic test_reset_mid();
    int exp[6] = '{-1, 'h6C, 'h30, 'h00, 'h0F, -2};
    bit hit, got, rdy, err; int lat, cyc, base, n0; logic [7:0] rd;
    log_q.delete(); nbytes = 0; n0 = done_cnt; base = scl_rises; hit = 0;
    cmd = 1'b1; addr_dev = 7'h36; addr_reg_H = 8'h30; addr_reg_L = 8'h00; data_wr_H = 8'h0F;
    i2c_rqt = 1'b1;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk); if (scl_rises - base >= 23) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_bit4 got=timeout exp=reached"); end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_bit4_drive got=%b exp=1", sda_oe); end
    rst = 1'b1; #1;
    checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got scl_oe=%b sda_oe=%b exp 0 0", scl_oe, sda_oe); end
    i2c_rqt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (done_cnt != n0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - n0); end
    log_q.delete(); nbytes = 0;
    do_xfer(1'b1, 8'h30, 8'h00, 8'h0F, 1, got, lat, cyc, rdy, rd, err);
    checks++; if (!got || lat != 2*CLK_DIV+1) begin errors++; $display("FAIL rstmid_rerun got done=%b lat=%0d exp 1 %0d", got, lat, 2*CLK_DIV+1); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL rstmid_log_len got=%0d exp=6", log_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (log_q[i] != exp[i]) begin errors++; $display("FAIL rstmid_log[%0d] got=%0d exp=%0d", i, log_q[i], exp[i]); end
    end
  endtask

  task automatic test_stretch();
    int exp[6] = '{-1, 'h6C, 'h30, 'h00, 'h0F, -2};
    bit got, rdy, err, hit; int lat, cyc, cyc0; logic [7:0] rd;
    log_q.delete(); nbytes = 0;
    do_xfer(1'b1, 8'h30, 8'h00, 8'h0F, 1, got, lat, cyc0, rdy, rd, err);
    log_q.delete(); nbytes = 0; stretch_en = 1; hit = 0;
    fork
      do_xfer(1'b1, 8'h30, 8'h00, 8'h0F, 1, got, lat, cyc, rdy, rd, err);
      begin
        for (int i = 0; i < 2000 && !hit; i++) begin @(negedge clk); if (stretch_cnt == 250) hit = 1; end
        checks++; if (!hit || scl !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b1) begin
          errors++; $display("FAIL stretch_mid got hit=%b scl=%b scl_oe=%b sda_oe=%b exp 1 0 0 1", hit, scl, scl_oe, sda_oe); end
      end
    join
    checks++; if (!got) begin errors++; $display("FAIL stretch_done got=0 exp=1"); end
    checks++; if (cyc - cyc0 < 485 || cyc - cyc0 > 500) begin
      errors++; $display("FAIL stretch_delay got=%0d exp=485..500", cyc - cyc0); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL stretch_log_len got=%0d exp=6", log_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (log_q[i] != exp[i]) begin errors++; $display("FAIL stretch_log[%0d] got=%0d exp=%0d", i, log_q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_hold_rqt();
    test_reset_mid();
    test_stretch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
